fs_serial_sub: RTL and testbench

Bit-serial multi-cycle subtractor that computes `D = A - B - bin` one bit per clock, LSB first, with a start/done handshake. It is the subtracting counterpart of the team's combinational ripple full-adder datapath and sits beside it in the arithmetic library. It trades latency for a single one-bit full-subtractor cell reused across cycles.

---
 rtl/fs_pkg.sv | 12 +
 rtl/fs_serial_sub_bit.sv | 15 +
 rtl/fs_serial_sub.sv | 160 ++++++++++++++++
 tb/tb_fs_serial_sub.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package fs_pkg;

    localparam int FS_DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fs_state_t;

endpackage

// File: rtl/fs_serial_sub_bit.sv
// One-bit full subtractor cell, reused every cycle by the serial datapath.
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    always_comb begin
        d      = a ^ b ^ br_in;
        br_out = (~a & b) | (~(a ^ b) & br_in);
    end

endmodule

// File: rtl/fs_serial_sub.sv
// Bit-serial subtractor D = A - B - bin, LSB first, start/done handshake.
// Optional signed-overflow output is built only when FS_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, result registers hold last value
// RUN   | one bit-step per clock, WIDTH steps total
// DONE  | one-cycle done pulse; start here chains the next operation
module fs_serial_sub
    import fs_pkg::*;
#(
    parameter int WIDTH = FS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef FS_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    fs_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             accept;

    logic bit_d, bit_br;

    fs_bit u_bit (
        .a      (a_sh_q[0]),
        .b      (b_sh_q[0]),
        .br_in  (br_q),
        .d      (bit_d),
        .br_out (bit_br)
    );

`ifdef FS_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        d_d     = d_q;
        bout_d  = bout_q;
        accept  = 1'b0;
`ifdef FS_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) accept = 1'b1;
            end
            RUN: begin
                a_sh_d        = a_sh_q >> 1;
                b_sh_d        = b_sh_q >> 1;
                res_d[idx_q]  = bit_d;
                br_d          = bit_br;
                idx_d         = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    // Publish the whole word at once; partial bits never reach d.
                    d_d     = res_d;
                    bout_d  = bit_br;
                    idx_d   = '0;
                    state_d = DONE;
`ifdef FS_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
                end
            end
            DONE: begin
                if (start) accept = 1'b1;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = b;
            br_d    = bin;
            idx_d   = '0;
            res_d   = '0;
            state_d = RUN;
`ifdef FS_OVF_EN
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
        end
    end

`ifdef FS_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // busy/done decode straight from the state register, so they stay glitch-free.
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_fs_serial_sub.sv
// Self-checking bench for fs_serial_sub: directed cases plus random operands
// against an arithmetic reference model.
module tb_fs_serial_sub;

    localparam int W    = 5;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef FS_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;
    int last_d = 0;
    int last_b = 0;
    int last_o = 0;

    fs_serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef FS_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int av, input int bv, input int bi,
                                  output int ed, output int eb, output int eo);
        int sa, sb, r;
        ed = (av - bv - bi) & MASK;
        eb = (av < bv + bi) ? 1 : 0;
        sa = (av >= HALF) ? av - (1 << W) : av;
        sb = (bv >= HALF) ? bv - (1 << W) : bv;
        r  = sa - sb - bi;
        eo = (r > HALF - 1 || r < -HALF) ? 1 : 0;
    endfunction

    // Called positioned at a negedge; returns in the done cycle.
    task automatic run_op(input int av, input int bv, input int bi, input int glitch);
        int ed, eb, eo;
        model(av, bv, bi, ed, eb, eo);
        a = W'(av); b = W'(bv); bin = bi[0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        for (int c = 1; c <= W; c++) begin
            chk($sformatf("busy_c%0d", c), busy, 1);
            chk($sformatf("nodone_c%0d", c), done, 0);
            if (c == glitch) begin
                start = 1'b1; a = W'(1); b = W'(1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done", done, 1);
        chk("busy_done", busy, 0);
        chk($sformatf("d_%0d-%0d-%0d", av, bv, bi), d, ed);
        chk($sformatf("bout_%0d-%0d-%0d", av, bv, bi), bout, eb);
`ifdef FS_OVF_EN
        chk($sformatf("ovf_%0d-%0d-%0d", av, bv, bi), ovf, eo);
        last_o = eo;
`endif
        last_d = ed;
        last_b = eb;
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_d", d, last_d);
        chk("idle_bout", bout, last_b);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_d", d, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_d", d, 0);
            chk("post_rst_bout", bout, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_done", done, 0);
        end

        run_op(13, 6, 0, 0);
        idle_chk();
        run_op(3, 5, 0, 0);
        idle_chk();
        run_op(31, 31, 1, 0);
        run_op(0, 0, 1, 0);
        idle_chk();
        run_op(20, 9, 0, 2);
        idle_chk();

        // Abort in the third RUN cycle.
        a = W'(25); b = W'(4); bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_d", d, 0);
        chk("abort_bout", bout, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_d = 0;
        last_b = 0;
        for (int i = 0; i < W + 2; i++) idle_chk();

`ifdef FS_OVF_EN
        run_op(16, 1, 0, 0);
        run_op(5, 3, 0, 0);
        idle_chk();
`endif

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(MASK, 0)), int'($urandom_range(MASK, 0)),
                   int'($urandom_range(1, 0)), 0);
            if ($urandom_range(1, 0) == 0) idle_chk();
        end
        idle_chk();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
